// File: rtl/branch_target_buffer_pkg.sv
// Shared definitions for the branch target buffer: default geometry,
// 2-bit saturating counter encodings, FSM states and counter helpers.
package branch_target_buffer_pkg;

    localparam int DEF_PC_W  = 13;
    localparam int DEF_IDX_W = 6;

    typedef enum logic [1:0] {
        CNT_SNT = 2'b00,
        CNT_WNT = 2'b01,
        CNT_WT  = 2'b10,
        CNT_ST  = 2'b11
    } cnt_t;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic cnt_t sat_inc(input cnt_t c);
        case (c)
            CNT_SNT: return CNT_WNT;
            CNT_WNT: return CNT_WT;
            default: return CNT_ST;
        endcase
    endfunction

    function automatic cnt_t sat_dec(input cnt_t c);
        case (c)
            CNT_ST:  return CNT_WT;
            CNT_WT:  return CNT_WNT;
            default: return CNT_SNT;
        endcase
    endfunction

endpackage

// File: rtl/branch_target_buffer_btb_ram.sv
// Entry storage for the branch target buffer: asynchronous read ports for
// the two fetch slots and the update path, one synchronous write port.
module btb_ram
    import branch_target_buffer_pkg::*;
#(
    parameter int IDX_W   = DEF_IDX_W,
    parameter int ENTRY_W = 1 + (DEF_PC_W - DEF_IDX_W) + DEF_PC_W + 2
) (
    input  logic               clk,
    input  logic               we,
    input  logic [IDX_W-1:0]   waddr,
    input  logic [ENTRY_W-1:0] wdata,
    input  logic [IDX_W-1:0]   raddr1,
    output logic [ENTRY_W-1:0] rdata1,
    input  logic [IDX_W-1:0]   raddr2,
    output logic [ENTRY_W-1:0] rdata2,
    input  logic [IDX_W-1:0]   raddr3,
    output logic [ENTRY_W-1:0] rdata3
);

    logic [ENTRY_W-1:0] mem [2**IDX_W];

    // No reset here: the top's init sweep clears every valid bit.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata1 = mem[raddr1];
    assign rdata2 = mem[raddr2];
    assign rdata3 = mem[raddr3];

endmodule

// File: rtl/branch_target_buffer.sv
// Dual-port direct-mapped branch target buffer: same-cycle lookups for two
// fetch slots, learning from resolved branches, with a post-reset clear sweep.
module branch_target_buffer
    import branch_target_buffer_pkg::*;
#(
    parameter int PC_W  = DEF_PC_W,
    parameter int IDX_W = DEF_IDX_W
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [PC_W-1:0] pc1,
    input  logic [PC_W-1:0] pc2,
    output logic            hit_predict1,
    output logic            hit_predict2,
    output logic [PC_W-1:0] pre_pc1,
    output logic [PC_W-1:0] pre_pc2,
    input  logic            upd_valid,
    input  logic [PC_W-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [PC_W-1:0] upd_target,
    output logic            btb_ready
);

    localparam int TAG_W   = PC_W - IDX_W;
    localparam int ENTRY_W = 1 + TAG_W + PC_W + 2;

    state_t             state, next_state;
    logic [IDX_W-1:0]   init_idx;
    logic               we;
    logic [IDX_W-1:0]   waddr;
    logic [ENTRY_W-1:0] wdata;
    logic [ENTRY_W-1:0] rd1, rd2, rdu;

    btb_ram #(
        .IDX_W   (IDX_W),
        .ENTRY_W (ENTRY_W)
    ) u_ram (
        .clk    (CLK),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .raddr1 (pc1[IDX_W-1:0]),
        .rdata1 (rd1),
        .raddr2 (pc2[IDX_W-1:0]),
        .rdata2 (rd2),
        .raddr3 (upd_pc[IDX_W-1:0]),
        .rdata3 (rdu)
    );

    // Entry layout: {valid, tag, target, cnt}
    logic            upd_match;
    logic [PC_W-1:0] upd_old_target;
    cnt_t            upd_cnt;

    assign upd_match      = rdu[ENTRY_W-1] && (rdu[ENTRY_W-2 -: TAG_W] == upd_pc[PC_W-1:IDX_W]);
    assign upd_old_target = rdu[PC_W+1:2];
    assign upd_cnt        = cnt_t'(rdu[1:0]);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= ST_INIT;
            init_idx <= '0;
        end else begin
            state <= next_state;
            if (state == ST_INIT) begin
                init_idx <= init_idx + 1'b1;
            end
        end
    end

    always_comb begin
        next_state = state;
        we         = 1'b0;
        waddr      = upd_pc[IDX_W-1:0];
        wdata      = rdu;
        case (state)
            ST_INIT: begin
                we    = 1'b1;
                waddr = init_idx;
                wdata = '0;
                if (init_idx == {IDX_W{1'b1}}) begin
                    next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (upd_valid) begin
                    if (upd_match) begin
                        we    = 1'b1;
                        wdata = {1'b1, upd_pc[PC_W-1:IDX_W],
                                 upd_taken ? upd_target : upd_old_target,
                                 upd_taken ? sat_inc(upd_cnt) : sat_dec(upd_cnt)};
                    end else if (upd_taken) begin
                        we    = 1'b1;
                        wdata = {1'b1, upd_pc[PC_W-1:IDX_W], upd_target, CNT_WT};
                    end
                end
            end
            default: next_state = ST_INIT;
        endcase
    end

    // Predict taken only for weak/strong-taken counters on a tag match.
    always_comb begin
        btb_ready    = (state == ST_RUN);
        hit_predict1 = btb_ready && rd1[ENTRY_W-1]
                       && (rd1[ENTRY_W-2 -: TAG_W] == pc1[PC_W-1:IDX_W])
                       && (rd1[1:0] >= CNT_WT);
        hit_predict2 = btb_ready && rd2[ENTRY_W-1]
                       && (rd2[ENTRY_W-2 -: TAG_W] == pc2[PC_W-1:IDX_W])
                       && (rd2[1:0] >= CNT_WT);
        pre_pc1      = hit_predict1 ? rd1[PC_W+1:2] : '0;
        pre_pc2      = hit_predict2 ? rd2[PC_W+1:2] : '0;
    end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Scoreboard bench for branch_target_buffer: a behavioural model predicts each
// cycle's lookup outputs, which are queued and compared mid-cycle.
module tb_branch_target_buffer;

    logic        CLK;
    logic        RST;
    logic [12:0] pc1, pc2;
    logic        hit_predict1, hit_predict2;
    logic [12:0] pre_pc1, pre_pc2;
    logic        upd_valid;
    logic [12:0] upd_pc;
    logic        upd_taken;
    logic [12:0] upd_target;
    logic        btb_ready;

    int error_count;
    int check_count;

    branch_target_buffer dut (
        .CLK          (CLK),
        .RST          (RST),
        .pc1          (pc1),
        .pc2          (pc2),
        .hit_predict1 (hit_predict1),
        .hit_predict2 (hit_predict2),
        .pre_pc1      (pre_pc1),
        .pre_pc2      (pre_pc2),
        .upd_valid    (upd_valid),
        .upd_pc       (upd_pc),
        .upd_taken    (upd_taken),
        .upd_target   (upd_target),
        .btb_ready    (btb_ready)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        ready;
        logic        hit1;
        logic [12:0] pre1;
        logic        hit2;
        logic [12:0] pre2;
    } exp_t;

    exp_t exp_q[$];

    logic        m_valid  [64];
    logic [6:0]  m_tag    [64];
    logic [12:0] m_target [64];
    logic [1:0]  m_cnt    [64];
    bit          m_run;
    int          m_idx;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic model_hit(input logic [12:0] pc);
        logic [5:0] i;
        i = pc[5:0];
        return m_run && m_valid[i] && (m_tag[i] == pc[12:6]) && (m_cnt[i] >= 2'd2);
    endfunction

    function automatic logic [12:0] model_pre(input logic [12:0] pc);
        return model_hit(pc) ? m_target[pc[5:0]] : 13'h0;
    endfunction

    // What the next posedge does to the stored state.
    task automatic model_step(input logic rst, input logic uv, input logic [12:0] upc,
                              input logic ut, input logic [12:0] utgt);
        logic [5:0] i;
        i = upc[5:0];
        if (rst) begin
            m_run = 1'b0;
            m_idx = 0;
        end else if (!m_run) begin
            m_valid[m_idx] = 1'b0;
            if (m_idx == 63) m_run = 1'b1;
            m_idx = (m_idx + 1) % 64;
        end else if (uv) begin
            if (m_valid[i] && m_tag[i] == upc[12:6]) begin
                if (ut) begin
                    m_cnt[i]    = (m_cnt[i] == 2'd3) ? 2'd3 : m_cnt[i] + 2'd1;
                    m_target[i] = utgt;
                end else begin
                    m_cnt[i] = (m_cnt[i] == 2'd0) ? 2'd0 : m_cnt[i] - 2'd1;
                end
            end else if (ut) begin
                m_valid[i]  = 1'b1;
                m_tag[i]    = upc[12:6];
                m_target[i] = utgt;
                m_cnt[i]    = 2'd2;
            end
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic [12:0] p1, input logic [12:0] p2,
                                 input logic uv, input logic [12:0] upc, input logic ut,
                                 input logic [12:0] utgt);
        exp_t e, got;
        RST        = rst;
        pc1        = p1;
        pc2        = p2;
        upd_valid  = uv;
        upd_pc     = upc;
        upd_taken  = ut;
        upd_target = utgt;
        e.ready = m_run;
        e.hit1  = model_hit(p1);
        e.pre1  = model_pre(p1);
        e.hit2  = model_hit(p2);
        e.pre2  = model_pre(p2);
        exp_q.push_back(e);
        @(negedge CLK);
        got = exp_q.pop_front();
        checkOutput("btb_ready",    {31'd0, btb_ready},    {31'd0, got.ready});
        checkOutput("hit_predict1", {31'd0, hit_predict1}, {31'd0, got.hit1});
        checkOutput("pre_pc1",      {19'd0, pre_pc1},      {19'd0, got.pre1});
        checkOutput("hit_predict2", {31'd0, hit_predict2}, {31'd0, got.hit2});
        checkOutput("pre_pc2",      {19'd0, pre_pc2},      {19'd0, got.pre2});
        model_step(rst, uv, upc, ut, utgt);
        @(posedge CLK);
        #1;
    endtask

    task automatic lookup(input logic [12:0] p1, input logic [12:0] p2);
        applyStimulus(1'b0, p1, p2, 1'b0, 13'h0, 1'b0, 13'h0);
    endtask

    task automatic update(input logic [12:0] upc, input logic ut, input logic [12:0] utgt);
        applyStimulus(1'b0, upc, upc + 13'd1, 1'b1, upc, ut, utgt);
    endtask

    initial begin
        logic [12:0] pcs [8];
        logic [12:0] ra, rb;
        pcs = '{13'h010, 13'h011, 13'h050, 13'h090, 13'h0D0, 13'h1FFF, 13'h1FC0, 13'h03F};
        error_count = 0;
        check_count = 0;
        for (int i = 0; i < 64; i++) begin
            m_valid[i]  = 1'b0;
            m_tag[i]    = '0;
            m_target[i] = '0;
            m_cnt[i]    = '0;
        end
        m_run = 1'b0;
        m_idx = 0;
        RST = 1'b1; pc1 = '0; pc2 = '0;
        upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
        @(posedge CLK);
        #1;

        $display("[TB] init sweep with dropped updates");
        for (int i = 0; i < 64; i++) begin
            applyStimulus(1'b0, 13'h010, 13'h011, 1'b1, 13'h010, 1'b1, 13'h1AA);
        end
        lookup(13'h010, 13'h011);

        $display("[TB] allocate and hit");
        update(13'h010, 1'b1, 13'h100);
        lookup(13'h010, 13'h011);
        lookup(13'h011, 13'h010);

        $display("[TB] counter saturation");
        for (int i = 0; i < 3; i++) update(13'h010, 1'b0, 13'h0);
        lookup(13'h010, 13'h011);
        for (int i = 0; i < 2; i++) update(13'h010, 1'b1, 13'h100);
        lookup(13'h010, 13'h011);
        for (int i = 0; i < 3; i++) update(13'h010, 1'b1, 13'h120);
        lookup(13'h010, 13'h011);

        $display("[TB] aliasing");
        update(13'h050, 1'b1, 13'h222);
        lookup(13'h050, 13'h090);
        update(13'h090, 1'b1, 13'h333);
        lookup(13'h090, 13'h050);
        update(13'h0D0, 1'b0, 13'h555);
        lookup(13'h090, 13'h0D0);

        $display("[TB] read during write");
        applyStimulus(1'b0, 13'h090, 13'h050, 1'b1, 13'h090, 1'b1, 13'h444);
        lookup(13'h090, 13'h050);
        update(13'h1FFF, 1'b1, 13'h0ABC);
        update(13'h1FC0, 1'b1, 13'h1234);
        lookup(13'h1FFF, 13'h1FC0);

        $display("[TB] random traffic");
        for (int i = 0; i < 150; i++) begin
            ra = pcs[$urandom_range(0, 7)];
            rb = pcs[$urandom_range(0, 7)];
            applyStimulus(1'b0, ra, rb, 1'($urandom_range(0, 1)),
                          pcs[$urandom_range(0, 7)], 1'($urandom_range(0, 1)),
                          13'($urandom_range(0, 8191)));
        end

        $display("[TB] reset during sweep");
        update(13'h090, 1'b1, 13'h777);
        update(13'h090, 1'b1, 13'h777);
        applyStimulus(1'b1, 13'h090, 13'h010, 1'b0, 13'h0, 1'b0, 13'h0);
        for (int i = 0; i < 20; i++) lookup(13'h090, 13'h010);
        applyStimulus(1'b1, 13'h090, 13'h010, 1'b0, 13'h0, 1'b0, 13'h0);
        for (int i = 0; i < 64; i++) lookup(13'h090, 13'h010);
        lookup(13'h090, 13'h010);
        update(13'h090, 1'b1, 13'h0F0);
        lookup(13'h090, 13'h010);

        $display("[TB] Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule
